jtag_counter_sequencer: RTL and testbench

- Command controller between tap_decoder and tap_encoder in the JTAG user-logic path.
- Decodes inbound command bytes and selects which TCK-domain counter is presented to the encoder.
- Supports manual select, auto-scan (select rotates on each Capture-DR) and per-counter or global clear pulses.
- Commands go through a 1-deep pending slot and a small FSM; errors and overflow are reported in a sticky flag carried in the response word.

---
 rtl/jtag_user_pkg.sv | 39 +++
 rtl/jtag_counter_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_jtag_counter_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_user_pkg.sv
// Shared opcodes, state/mode types and the response-word packer for the JTAG user-logic command path.
// Holds no logic of its own, so it adds no latency.
// Holds no logic of its own, so it has no backpressure behaviour.
package jtag_user_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP    = 4'h0;
  localparam cmd_t CMD_SELECT = 4'h9;
  localparam cmd_t CMD_AUTO   = 4'hA;
  localparam cmd_t CMD_CLEAR  = 4'hB;
  localparam cmd_t CMD_ACK    = 4'hF;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EXEC       = 2'd1,
    ST_CLEAR_HOLD = 2'd2
  } state_e;

  // Packs {sel, err, count} into the low bits of a 64-bit word.
  // cw is the counter width. The caller truncates the result to its response width.
  // This supports a counter width of up to 32 bits and a select width of up to 31 bits.
  function automatic logic [63:0] pack_resp(input logic [31:0] sel,
                                            input logic        err,
                                            input logic [31:0] count,
                                            input int unsigned cw);
    logic [63:0] w;
    w = {32'd0, count};
    w = w | ({63'd0, err} << cw);
    w = w | ({32'd0, sel} << (cw + 1));
    return w;
  endfunction

endpackage

// File: rtl/jtag_counter_sequencer.sv
// Purpose: decodes command bytes from tap_decoder and selects the counter value that tap_encoder shifts out.
// Latency: a command byte seen on an idle FSM executes on the next cycle, and its effects are visible the cycle after that.
// Backpressure: none. A 1-deep pending slot absorbs one byte; a byte that arrives while the slot is full is dropped and sets err_flag.
// Ports:
//   tck / test_logic_reset_n   : clock and async active-low reset
//   inbound_valid/inbound_data : command strobe and byte {opcode[7:4], arg[3:0]}
//   capture_dr                 : sample the selected counter into resp_data
//   count_in                   : packed counter values, counter i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   clear                      : per-counter clear pulse, CLEAR_CYCLES long
//   resp_valid/resp_data       : response word {sel, err_flag, count}
module jtag_counter_sequencer
  import jtag_user_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS  = 8,
  parameter int unsigned COUNTER_WIDTH = 28,
  parameter int unsigned CLEAR_CYCLES  = 2
) (
  input  logic                                       tck,
  input  logic                                       test_logic_reset_n,
  input  logic                                       inbound_valid,
  input  logic [7:0]                                 inbound_data,
  input  logic                                       capture_dr,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]      count_in,
  output logic [NUM_COUNTERS-1:0]                    clear,
  output logic                                       resp_valid,
  output logic [$clog2(NUM_COUNTERS)+COUNTER_WIDTH:0] resp_data
);

  localparam int unsigned SW = $clog2(NUM_COUNTERS);
  localparam int unsigned RW = SW + 1 + COUNTER_WIDTH;
  localparam int unsigned HW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  logic [COUNTER_WIDTH-1:0] cnt_arr [NUM_COUNTERS];

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_unpack
    assign cnt_arr[i] = count_in[i*COUNTER_WIDTH +: COUNTER_WIDTH];
  end

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic                    err_q, err_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [7:0]              pend_dat_q, pend_dat_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [NUM_COUNTERS-1:0] clear_q, clear_d;
  logic                    resp_vld_q, resp_vld_d;
  logic [RW-1:0]           resp_dat_q, resp_dat_d;

  cmd_t                    exec_op;
  logic [3:0]              exec_arg;
  logic                    consume;
  logic                    bypass;
  logic                    exec_select;
  logic                    err_set;
  logic                    err_clr;
  logic                    clr_bad;
  logic [NUM_COUNTERS-1:0] clr_mask;

  assign exec_op  = cmd_q[7:4];
  assign exec_arg = cmd_q[3:0];

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    err_d       = err_q;
    pend_vld_d  = pend_vld_q;
    pend_dat_d  = pend_dat_q;
    cmd_d       = cmd_q;
    hold_d      = hold_q;
    clear_d     = '0;
    resp_vld_d  = resp_vld_q;
    resp_dat_d  = resp_dat_q;
    consume     = 1'b0;
    bypass      = 1'b0;
    exec_select = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    clr_bad     = 1'b0;
    clr_mask    = '0;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          cmd_d   = pend_dat_q;
          state_d = ST_EXEC;
          consume = 1'b1;
        end else if (inbound_valid) begin
          // When the slot is empty, a fresh byte goes straight to EXEC.
          // This gives the one-cycle command latency.
          cmd_d   = inbound_data;
          state_d = ST_EXEC;
          bypass  = 1'b1;
        end
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        case (exec_op)
          CMD_NOP: ;
          CMD_SELECT: begin
            sel_d       = exec_arg[SW-1:0];
            mode_d      = MODE_MANUAL;
            exec_select = 1'b1;
          end
          CMD_AUTO: mode_d = MODE_AUTO;
          CMD_CLEAR: begin
            if (exec_arg[3]) begin
              clr_mask = '1;
            end else if (32'(exec_arg[2:0]) >= NUM_COUNTERS) begin
              clr_bad = 1'b1;
            end else begin
              clr_mask = NUM_COUNTERS'(1) << exec_arg[2:0];
            end
            if (clr_bad) begin
              err_set = 1'b1;
            end else begin
              clear_d = clr_mask;
              hold_d  = HW'(CLEAR_CYCLES - 1);
              if (CLEAR_CYCLES > 1) state_d = ST_CLEAR_HOLD;
            end
          end
          CMD_ACK: err_clr = 1'b1;
          default: err_set = 1'b1;
        endcase
      end

      ST_CLEAR_HOLD: begin
        if (hold_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d  = hold_q - HW'(1);
          clear_d = clear_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Pending slot. The slot frees in the same cycle it is consumed, so a byte arriving then is still accepted.
    if (inbound_valid && !bypass) begin
      if (!pend_vld_q || consume) begin
        pend_vld_d = 1'b1;
        pend_dat_d = inbound_data;
      end else begin
        err_set = 1'b1;
      end
    end else if (consume) begin
      pend_vld_d = 1'b0;
    end

    // If an ACK and an error land in the same cycle, the set wins.
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;

    // Capture samples the pre-update sel and err_flag.
    // An executing SELECT owns sel in that cycle, so there is no auto-advance then.
    if (capture_dr) begin
      resp_dat_d = RW'(pack_resp(32'(sel_q), err_q, 32'(cnt_arr[sel_q]), COUNTER_WIDTH));
      resp_vld_d = 1'b1;
      if (mode_q == MODE_AUTO && !exec_select) sel_d = sel_q + SW'(1);
    end
  end

  always_ff @(posedge tck or negedge test_logic_reset_n) begin
    if (!test_logic_reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_MANUAL;
      sel_q      <= '0;
      err_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      cmd_q      <= '0;
      hold_q     <= '0;
      clear_q    <= '0;
      resp_vld_q <= 1'b0;
      resp_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      cmd_q      <= cmd_d;
      hold_q     <= hold_d;
      clear_q    <= clear_d;
      resp_vld_q <= resp_vld_d;
      resp_dat_q <= resp_dat_d;
    end
  end

  assign clear      = clear_q;
  assign resp_valid = resp_vld_q;
  assign resp_data  = resp_dat_q;

endmodule

// File: tb/tb_jtag_counter_sequencer.sv
// Bench for jtag_counter_sequencer.
// It uses directed scenarios plus randomized commands and captures, checked against a transaction-level model.
module tb_jtag_counter_sequencer;

  localparam int N  = 8;
  localparam int CW = 28;
  localparam int CC = 2;

  logic            tck = 1'b0;
  logic            rst_n;
  logic            inbound_valid;
  logic [7:0]      inbound_data;
  logic            capture_dr;
  logic [N*CW-1:0] count_in;
  logic [N-1:0]    clear;
  logic            resp_valid;
  logic [31:0]     resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, tracked at command and capture granularity.
  logic [2:0]    m_sel;
  logic          m_auto;
  logic          m_err;
  logic [CW-1:0] cnt [N];

  jtag_counter_sequencer #(.NUM_COUNTERS(N), .COUNTER_WIDTH(CW), .CLEAR_CYCLES(CC)) dut (
    .tck               (tck),
    .test_logic_reset_n(rst_n),
    .inbound_valid     (inbound_valid),
    .inbound_data      (inbound_data),
    .capture_dr        (capture_dr),
    .count_in          (count_in),
    .clear             (clear),
    .resp_valid        (resp_valid),
    .resp_data         (resp_data)
  );

  always #5 tck = ~tck;

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic drive_counts();
    for (int i = 0; i < N; i++) count_in[i*CW +: CW] = cnt[i];
  endtask

  task automatic model_reset();
    m_sel  = 3'd0;
    m_auto = 1'b0;
    m_err  = 1'b0;
  endtask

  // Applies one command to the model and returns the clear mask it should pulse.
  function automatic logic [7:0] model_apply(input logic [7:0] b);
    logic [3:0] op;
    logic [3:0] arg;
    logic [7:0] mask;
    op   = b[7:4];
    arg  = b[3:0];
    mask = 8'h00;
    case (op)
      4'h0: ;
      4'h9: begin m_sel = arg[2:0]; m_auto = 1'b0; end
      4'hA: m_auto = 1'b1;
      4'hB: mask = arg[3] ? 8'hFF : (8'h01 << arg[2:0]);
      4'hF: m_err = 1'b0;
      default: m_err = 1'b1;
    endcase
    return mask;
  endfunction

  // Sends one byte to an idle DUT.
  // The clear pulse must appear at t+2 and last exactly CC cycles.
  task automatic send_cmd(input logic [7:0] b);
    logic [7:0] mask;
    logic [7:0] exp;
    int bad;
    mask = model_apply(b);
    inbound_valid = 1'b1;
    inbound_data  = b;
    step();
    inbound_valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      exp = (k >= 2 && k <= 1 + CC) ? mask : 8'h00;
      if (clear !== exp) bad++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clear_pulse cmd=%h: %0d cycles with the wrong clear value, required 0 (mask %h)", b, bad, mask);
    end
  endtask

  task automatic capture_check(input string name);
    logic [31:0] exp;
    exp = {m_sel, m_err, cnt[m_sel]};
    capture_dr = 1'b1;
    step();
    capture_dr = 1'b0;
    n_checks++;
    if (resp_data !== exp) begin
      n_fail++;
      $display("FAIL %s resp_data: got %h, required %h", name, resp_data, exp);
    end
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s resp_valid: got %b, required 1", name, resp_valid);
    end
    if (m_auto) m_sel = m_sel + 3'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inbound_valid = 1'b0;
    inbound_data = 8'h00;
    capture_dr = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = CW'($urandom);
    cnt[0] = 28'h0000123;
    drive_counts();
    model_reset();
    step();
    step();
    n_checks++;
    if ({clear, resp_valid, resp_data} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: clear=%h resp_valid=%b resp_data=%h, required all zero", clear, resp_valid, resp_data);
    end
    rst_n = 1'b1;
    step();
    capture_check("reset_capture");
  endtask

  task automatic test_select();
    cnt[5] = 28'hCAFEDEC;
    drive_counts();
    model_apply(8'h95);
    inbound_valid = 1'b1;
    inbound_data  = 8'h95;
    step();
    inbound_valid = 1'b0;
    step();
    // Two cycles after the strobe the new sel must already be in effect.
    capture_check("select_latency");
  endtask

  task automatic test_auto_scan();
    logic [2:0] seq [4];
    send_cmd(8'h96);
    send_cmd(8'hA0);
    seq[0] = 3'd6;
    seq[1] = 3'd7;
    seq[2] = 3'd0;
    seq[3] = 3'd1;
    for (int i = 0; i < 4; i++) begin
      capture_check("auto_scan");
      n_checks++;
      if (resp_data[31:29] !== seq[i]) begin
        n_fail++;
        $display("FAIL auto_scan_seq[%0d]: got sel %0d, required %0d", i, resp_data[31:29], seq[i]);
      end
    end
  endtask

  task automatic test_clear();
    send_cmd(8'hB3);
    send_cmd(8'hB8);
  endtask

  task automatic test_error_ack();
    send_cmd(8'h50);
    capture_check("err_set");
    send_cmd(8'hF0);
    capture_check("err_ack");
  endtask

  // A capture in the same cycle as a SELECT executing in AUTO mode.
  task automatic test_capture_select();
    logic [31:0] exp;
    send_cmd(8'hA0);
    exp = {m_sel, m_err, cnt[m_sel]};
    inbound_valid = 1'b1;
    inbound_data  = 8'h92;
    step();
    inbound_valid = 1'b0;
    capture_dr = 1'b1;
    step();
    capture_dr = 1'b0;
    n_checks++;
    if (resp_data !== exp) begin
      n_fail++;
      $display("FAIL capture_vs_select: got %h, required %h", resp_data, exp);
    end
    model_apply(8'h92);
    step();
    step();
    capture_check("select_wins");
  endtask

  // Bytes arrive while a clear is held. The first is queued and the next two are dropped.
  task automatic test_overflow();
    logic [7:0] seq [5];
    logic [7:0] clr_seen [5];
    send_cmd(8'hF0);
    send_cmd(8'h97);
    seq[0] = 8'hB3;
    seq[1] = 8'h92;
    seq[2] = 8'h93;
    seq[3] = 8'h94;
    seq[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      inbound_valid = (i < 4);
      inbound_data  = seq[i];
      clr_seen[i] = clear;
      step();
    end
    inbound_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (clr_seen[2] !== 8'h08 || clr_seen[3] !== 8'h08 || clr_seen[4] !== 8'h00) begin
      n_fail++;
      $display("FAIL overflow_clear: got %h %h %h, required 08 08 00", clr_seen[2], clr_seen[3], clr_seen[4]);
    end
    m_sel  = 3'd2;
    m_auto = 1'b0;
    m_err  = 1'b1;
    capture_check("overflow");
  endtask

  // An ACK executes in the same cycle that a byte is dropped. The error set must win.
  task automatic test_ack_vs_drop();
    logic [7:0] seq [6];
    logic [1:0] vld [6];
    send_cmd(8'hF0);
    seq[0] = 8'hB3; seq[1] = 8'hF0; seq[2] = 8'h00;
    seq[3] = 8'h00; seq[4] = 8'h00; seq[5] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      vld[i] = (i == 0 || i == 1 || i == 4 || i == 5) ? 2'd1 : 2'd0;
      inbound_valid = vld[i][0];
      inbound_data  = seq[i];
      step();
    end
    inbound_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    m_err = 1'b1;
    capture_check("ack_vs_drop");
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [3:0] arg;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < N; i++) cnt[i] = CW'($urandom);
        drive_counts();
        capture_check("random_capture");
      end else begin
        arg = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 5))
          0: op = 4'h0;
          1: op = 4'h9;
          2: op = 4'hA;
          3: op = 4'hB;
          4: op = 4'hF;
          default: op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(12, 14));
        endcase
        send_cmd({op, arg});
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    inbound_valid = 1'b1;
    inbound_data  = 8'hB8;
    step();
    inbound_data  = 8'h97;
    step();
    inbound_valid = 1'b0;
    n_checks++;
    if (clear !== 8'hFF) begin
      n_fail++;
      $display("FAIL hold_before_reset: clear=%h, required ff", clear);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (clear !== 8'h00 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: clear=%h resp_valid=%b, required 00 0", clear, resp_valid);
    end
    step();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step();
    capture_check("pending_lost");
  endtask

  initial begin
    test_reset();
    test_select();
    test_auto_scan();
    test_clear();
    test_error_ack();
    test_capture_select();
    test_overflow();
    test_ack_vs_drop();
    test_random();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
